// File: rtl/gpr_sb_pkg.sv
// Shared constants and types for the GPR read scoreboard.
package gpr_sb_pkg;
    localparam int          CNT_W_DEF = 2;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam int          CNT_MAX   = 2**CNT_W_DEF - 1;

    typedef logic [CNT_W_DEF-1:0] cnt_t;
endpackage

// File: rtl/gpr_sb_cell.sv
// One pending-write counter: saturating up/down with synchronous clear.
// underflow flags a decrement against an empty counter (ignored while clr).
module gpr_sb_cell #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);
    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign underflow = dec & ~clr & (cnt == '0);

    // inc and dec together cancel; the count never wraps in either direction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != MAX) begin
            cnt <= cnt + ONE;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - ONE;
        end
    end
endmodule

// File: rtl/gpr_read_scoreboard.sv
// D-stage read scoreboard: counts in-flight writes per GPR and stalls reads
// of registers that still have writes pending.
// Optional macro WBYPASS_EN: a retire that drains the last pending write of
// a register unblocks reads of it in the same cycle (W-to-D forwarding).
module gpr_read_scoreboard
    import gpr_sb_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       issue_valid,
    input  logic [4:0] issue_dst,
    input  logic [4:0] rd_a1,
    input  logic [4:0] rd_a2,
    input  logic       rd_use1,
    input  logic       rd_use2,
    input  logic       retire_valid,
    input  logic [4:0] retire_dst,
    input  logic       flush,
    output logic       stall,
    output logic       busy1,
    output logic       busy2,
    output logic       err
);
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:1]            uf;
    logic                       iss;
    logic                       ret;
    logic                       sat;
    logic                       fwd1;
    logic                       fwd2;

    // register 0 is never written, so it never has anything pending
    assign cnt[0] = '0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_cell
            gpr_sb_cell #(.CNT_W(CNT_W)) u_cell (
                .clk       (clk),
                .reset_n   (reset_n),
                .inc       (iss && issue_dst == 5'(r)),
                .dec       (ret && retire_dst == 5'(r)),
                .clr       (flush),
                .cnt       (cnt[r]),
                .underflow (uf[r])
            );
        end
    endgenerate

    // read-side hazard detection, recomputed from the counters every cycle
    always_comb begin
        ret = retire_valid && (retire_dst != REG_ZERO);
`ifdef WBYPASS_EN
        fwd1 = ret && (retire_dst == rd_a1) && (cnt[rd_a1] == ONE);
        fwd2 = ret && (retire_dst == rd_a2) && (cnt[rd_a2] == ONE);
`else
        fwd1 = 1'b0;
        fwd2 = 1'b0;
`endif
        busy1 = (rd_a1 != REG_ZERO) && (cnt[rd_a1] != '0) && !fwd1;
        busy2 = (rd_a2 != REG_ZERO) && (cnt[rd_a2] != '0) && !fwd2;
        // a full counter cannot absorb another write, so hold the issue
        sat   = issue_valid && (issue_dst != REG_ZERO) && (cnt[issue_dst] == CMAX);
        stall = (rd_use1 && busy1) || (rd_use2 && busy2) || sat;
        iss   = issue_valid && !stall && (issue_dst != REG_ZERO);
    end

    // sticky error: any retire that found nothing pending
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (|uf) begin
            err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gpr_read_scoreboard.sv
// Self-checking bench for gpr_read_scoreboard: directed scenarios plus a
// randomized run against a per-register pending-count model.
module tb_gpr_read_scoreboard;
    logic       clk;
    logic       reset_n;
    logic       issue_valid;
    logic [4:0] issue_dst;
    logic [4:0] rd_a1;
    logic [4:0] rd_a2;
    logic       rd_use1;
    logic       rd_use2;
    logic       retire_valid;
    logic [4:0] retire_dst;
    logic       flush;
    logic       stall;
    logic       busy1;
    logic       busy2;
    logic       err;

    int checks   = 0;
    int failures = 0;

    gpr_read_scoreboard dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .issue_valid  (issue_valid),
        .issue_dst    (issue_dst),
        .rd_a1        (rd_a1),
        .rd_a2        (rd_a2),
        .rd_use1      (rd_use1),
        .rd_use2      (rd_use2),
        .retire_valid (retire_valid),
        .retire_dst   (retire_dst),
        .flush        (flush),
        .stall        (stall),
        .busy1        (busy1),
        .busy2        (busy2),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int mcnt [32];
    bit merr;

    function automatic bit m_busy(input logic [4:0] a);
        if (a == 5'd0 || mcnt[a] == 0) return 1'b0;
`ifdef WBYPASS_EN
        if (retire_valid && retire_dst == a && mcnt[a] == 1) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        bit s;
        s = (rd_use1 && m_busy(rd_a1)) || (rd_use2 && m_busy(rd_a2));
        if (issue_valid && issue_dst != 5'd0 && mcnt[issue_dst] == 3) s = 1'b1;
        return s;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        bit mi, mr;
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mcnt[i] <= 0;
            merr <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < 32; i++) mcnt[i] <= 0;
        end else begin
            mi = issue_valid && !m_stall() && issue_dst != 5'd0;
            mr = retire_valid && retire_dst != 5'd0;
            if (mi && !(mr && retire_dst == issue_dst))
                mcnt[issue_dst] <= mcnt[issue_dst] + 1;
            if (mr && !(mi && retire_dst == issue_dst) && mcnt[retire_dst] > 0)
                mcnt[retire_dst] <= mcnt[retire_dst] - 1;
            if (mr && mcnt[retire_dst] == 0)
                merr <= 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit iv, input logic [4:0] id, input logic [4:0] a1,
                         input logic [4:0] a2, input bit u1, input bit u2,
                         input bit rv, input logic [4:0] rd, input bit fl);
        issue_valid  = iv;
        issue_dst    = id;
        rd_a1        = a1;
        rd_a2        = a2;
        rd_use1      = u1;
        rd_use2      = u2;
        retire_valid = rv;
        retire_dst   = rd;
        flush        = fl;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 0, 5'd5, 5'd6, 1, 1, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy1 got=%0b exp=0", busy1); end
        checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL reset_busy2 got=%0b exp=0", busy2); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
        tick();
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_raw_stall();
        bit exp_t2;
`ifdef WBYPASS_EN
        exp_t2 = 1'b0;
`else
        exp_t2 = 1'b1;
`endif
        drive(1, 5'd5, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_t0_stall got=%0b exp=0", stall); end
        tick();
        drive(0, 0, 5'd5, 0, 1, 0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_t1_stall got=%0b exp=1", stall); end
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL raw_t1_busy1 got=%0b exp=1", busy1); end
        tick();
        drive(0, 0, 5'd5, 0, 1, 0, 1, 5'd5, 0);
        checks++; if (stall !== exp_t2) begin failures++; $display("FAIL raw_t2_stall got=%0b exp=%0b", stall, exp_t2); end
        tick();
        drive(0, 0, 5'd5, 0, 1, 0, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL raw_t3_stall got=%0b exp=0", stall); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL raw_t3_busy1 got=%0b exp=0", busy1); end
        tick();
    endtask

    task automatic test_zero_reg();
        drive(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL zero_issue_stall got=%0b exp=0", stall); end
        tick();
        drive(0, 0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL zero_read_stall got=%0b exp=0", stall); end
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL zero_busy got=%0b%0b exp=00", busy1, busy2); end
        tick();
    endtask

    task automatic test_saturate();
        bit eb;
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
            checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sat_issue%0d_stall got=%0b exp=0", k, stall); end
            tick();
        end
        drive(1, 5'd7, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_fourth_stall got=%0b exp=1", stall); end
        tick();
        // draining exactly three retires must empty the register
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 5'd7, 0, 1, 0, 1, 5'd7, 0);
            eb = 1'b1;
`ifdef WBYPASS_EN
            if (k == 2) eb = 1'b0;
`endif
            checks++; if (busy1 !== eb) begin failures++; $display("FAIL sat_drain%0d_busy1 got=%0b exp=%0b", k, busy1, eb); end
            tick();
        end
        drive(0, 0, 5'd7, 0, 1, 0, 0, 0, 0);
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL sat_empty_busy1 got=%0b exp=0", busy1); end
        tick();
    endtask

    task automatic test_same_cycle();
        bit eb;
`ifdef WBYPASS_EN
        eb = 1'b0;
`else
        eb = 1'b1;
`endif
        drive(1, 5'd9, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 5'd9, 5'd9, 0, 0, 0, 1, 5'd9, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL same_stall got=%0b exp=0", stall); end
        checks++; if (busy1 !== eb) begin failures++; $display("FAIL same_busy1 got=%0b exp=%0b", busy1, eb); end
        tick();
        drive(0, 0, 5'd9, 0, 0, 0, 0, 0, 0);
        checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL same_after_busy1 got=%0b exp=1", busy1); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 0);
        tick();
        drive(0, 0, 5'd9, 0, 1, 0, 0, 0, 0);
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL same_drained_busy1 got=%0b exp=0", busy1); end
        tick();
    endtask

    task automatic test_underflow();
        drive(0, 0, 5'd12, 0, 1, 0, 1, 5'd12, 0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL uf_before_err got=%0b exp=0", err); end
        tick();
        drive(0, 0, 5'd12, 0, 1, 0, 0, 0, 0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL uf_err got=%0b exp=1", err); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL uf_busy1 got=%0b exp=0", busy1); end
        tick();
        drive(1, 5'd12, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 5'd12, 0);
        tick();
        drive(0, 0, 5'd12, 0, 1, 0, 0, 0, 0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL uf_sticky_err got=%0b exp=1", err); end
        checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL uf_after_busy1 got=%0b exp=0", busy1); end
        tick();
    endtask

    task automatic test_random();
        bit es, eb1, eb2, ee;
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 6)),
                  5'($urandom_range(0, 6)), 5'($urandom_range(0, 6)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 6)),
                  $urandom_range(0, 39) == 0);
            es  = m_stall();
            eb1 = m_busy(rd_a1);
            eb2 = m_busy(rd_a2);
            ee  = merr;
            checks++; if (stall !== es) begin failures++; $display("FAIL rnd%0d_stall got=%0b exp=%0b", n, stall, es); end
            checks++; if (busy1 !== eb1) begin failures++; $display("FAIL rnd%0d_busy1 got=%0b exp=%0b", n, busy1, eb1); end
            checks++; if (busy2 !== eb2) begin failures++; $display("FAIL rnd%0d_busy2 got=%0b exp=%0b", n, busy2, eb2); end
            checks++; if (err !== ee) begin failures++; $display("FAIL rnd%0d_err got=%0b exp=%0b", n, err, ee); end
            tick();
        end
        // settle back to an empty scoreboard
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_flush_reset();
        drive(1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 5'd3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 5'd4, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 5'd3, 5'd4, 1, 1, 1, 5'd3, 1);
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL flush_cycle_stall got=%0b exp=1", stall); end
        tick();
        drive(0, 0, 5'd3, 5'd4, 1, 1, 0, 0, 0);
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL flush_after_stall got=%0b exp=0", stall); end
        checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin failures++; $display("FAIL flush_after_busy got=%0b%0b exp=00", busy1, busy2); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL flush_keeps_err got=%0b exp=1", err); end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL async_reset_err got=%0b exp=0", err); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL async_reset_stall got=%0b exp=0", stall); end
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_raw_stall();
        test_zero_reg();
        test_saturate();
        test_same_cycle();
        test_underflow();
        test_random();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
